// File: rtl/rc4_ksa_engine.sv
// rtl/rc4_ksa_engine.sv - RC4 key-scheduling engine driving an external state RAM (optional fill: RC4_KSA_INIT_FILL_EN)
module rc4_ksa_engine #(
  parameter int W       = 8,
  parameter int KEY_LEN = 3,
  parameter int RD_LAT  = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [KEY_LEN*W-1:0]   key,
  output logic                   busy,
  output logic                   done,
  output logic [W-1:0]           mem_addr,
  output logic [W-1:0]           mem_wdata,
  output logic                   mem_wren,
  input  logic [W-1:0]           mem_rdata
);

  localparam int              KW        = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [W-1:0]    LAST_IDX  = '1;
  localparam logic [KW-1:0]   LAST_K    = KW'(KEY_LEN - 1);
  localparam logic [1:0]      LAST_WAIT = 2'(RD_LAT - 1);

  typedef enum logic [3:0] {
    IDLE, FILL, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J, NEXT, DONE
  } state_t;

`ifdef RC4_KSA_INIT_FILL_EN
  localparam state_t FIRST = FILL;
`else
  localparam state_t FIRST = RD_I;
`endif

  state_t                 state, state_nxt;
  logic [W-1:0]           i_q, j_q, si_q, sj_q;
  logic [KW-1:0]          k_q;
  logic [1:0]             wait_q;
  logic [KEY_LEN*W-1:0]   key_q;
  logic [W-1:0]           key_word;

  // Select latched key word k; word 0 sits in the most-significant bits.
  always_comb begin
    key_word = '0;
    for (int m = 0; m < KEY_LEN; m++) begin
      if (k_q == KW'(m)) key_word = key_q[(KEY_LEN-1-m)*W +: W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic and Moore-decoded memory/status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FIRST;
      end
`ifdef RC4_KSA_INIT_FILL_EN
      FILL: begin
        busy      = 1'b1;
        mem_addr  = i_q;
        mem_wdata = i_q;
        mem_wren  = 1'b1;
        if (i_q == LAST_IDX) state_nxt = RD_I;
      end
`endif
      RD_I: begin
        busy      = 1'b1;
        mem_addr  = i_q;
        state_nxt = WAIT_I;
      end
      WAIT_I: begin
        busy = 1'b1;
        if (wait_q == LAST_WAIT) state_nxt = CALC_J;
      end
      CALC_J: begin
        busy      = 1'b1;
        state_nxt = RD_J;
      end
      RD_J: begin
        busy      = 1'b1;
        mem_addr  = j_q;
        state_nxt = WAIT_J;
      end
      WAIT_J: begin
        busy = 1'b1;
        if (wait_q == LAST_WAIT) state_nxt = WR_I;
      end
      WR_I: begin
        busy      = 1'b1;
        mem_addr  = i_q;
        mem_wdata = sj_q;
        mem_wren  = 1'b1;
        state_nxt = WR_J;
      end
      WR_J: begin
        busy      = 1'b1;
        mem_addr  = j_q;
        mem_wdata = si_q;
        mem_wren  = 1'b1;
        state_nxt = NEXT;
      end
      NEXT: begin
        busy      = 1'b1;
        state_nxt = (i_q == LAST_IDX) ? DONE : RD_I;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = FIRST;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Index, key and swap-operand registers; the i==j case needs no special
  // handling because both writes then carry the same value to one address.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      i_q    <= '0;
      j_q    <= '0;
      k_q    <= '0;
      si_q   <= '0;
      sj_q   <= '0;
      wait_q <= '0;
      key_q  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            key_q <= key;
            i_q   <= '0;
            j_q   <= '0;
            k_q   <= '0;
          end
        end
`ifdef RC4_KSA_INIT_FILL_EN
        FILL: i_q <= i_q + 1'b1;
`endif
        RD_I: wait_q <= '0;
        WAIT_I: begin
          wait_q <= wait_q + 1'b1;
          if (wait_q == LAST_WAIT) si_q <= mem_rdata;
        end
        CALC_J: j_q <= j_q + si_q + key_word;
        RD_J: wait_q <= '0;
        WAIT_J: begin
          wait_q <= wait_q + 1'b1;
          if (wait_q == LAST_WAIT) sj_q <= mem_rdata;
        end
        NEXT: begin
          if (i_q != LAST_IDX) begin
            i_q <= i_q + 1'b1;
            k_q <= (k_q == LAST_K) ? '0 : k_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb/tb_rc4_ksa_engine.sv - directed self-checking bench for rc4_ksa_engine
module tb_rc4_ksa_engine;

`ifdef RC4_KSA_INIT_FILL_EN
  localparam int FILL_ON = 1;
`else
  localparam int FILL_ON = 0;
`endif

  logic clk, reset_n, load;
  logic start_a, start_b, start_c;
  logic [23:0] key8;
  logic [1:0]  key2;

  logic busy_a, done_a, wren_a; logic [7:0] addr_a, wdata_a, rdata_a;
  logic busy_b, done_b, wren_b; logic [7:0] addr_b, wdata_b, rdata_b;
  logic busy_c, done_c, wren_c; logic [1:0] addr_c, wdata_c, rdata_c;

  int n_checks = 0;
  int n_pass   = 0;
  int sel      = 0;
  logic [7:0] exp8 [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rc4_ksa_engine #(.W(8), .KEY_LEN(3), .RD_LAT(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .key(key8), .busy(busy_a), .done(done_a),
    .mem_addr(addr_a), .mem_wdata(wdata_a), .mem_wren(wren_a), .mem_rdata(rdata_a));
  rc4_ksa_engine #(.W(8), .KEY_LEN(3), .RD_LAT(3)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .key(key8), .busy(busy_b), .done(done_b),
    .mem_addr(addr_b), .mem_wdata(wdata_b), .mem_wren(wren_b), .mem_rdata(rdata_b));
  rc4_ksa_engine #(.W(2), .KEY_LEN(1), .RD_LAT(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .start(start_c), .key(key2), .busy(busy_c), .done(done_c),
    .mem_addr(addr_c), .mem_wdata(wdata_c), .mem_wren(wren_c), .mem_rdata(rdata_c));

  // State RAM models: with fill enabled they preload junk so the fill is observable.
  logic [7:0] mem_a [256]; logic [7:0] pa0;
  logic [7:0] mem_b [256]; logic [7:0] pb0, pb1, pb2;
  logic [1:0] mem_c [4];   logic [1:0] pc0;

  always @(posedge clk) begin
    pa0 <= mem_a[addr_a];
    if (load) for (int m = 0; m < 256; m++) mem_a[m] <= (FILL_ON != 0) ? 8'(255 - m) : 8'(m);
    else if (wren_a) mem_a[addr_a] <= wdata_a;
  end
  always @(posedge clk) begin
    pb0 <= mem_b[addr_b]; pb1 <= pb0; pb2 <= pb1;
    if (load) for (int m = 0; m < 256; m++) mem_b[m] <= (FILL_ON != 0) ? 8'(255 - m) : 8'(m);
    else if (wren_b) mem_b[addr_b] <= wdata_b;
  end
  always @(posedge clk) begin
    pc0 <= mem_c[addr_c];
    if (load) for (int m = 0; m < 4; m++) mem_c[m] <= (FILL_ON != 0) ? 2'(3 - m) : 2'(m);
    else if (wren_c) mem_c[addr_c] <= wdata_c;
  end
  assign rdata_a = pa0;
  assign rdata_b = pb2;
  assign rdata_c = pc0;

  logic cur_busy, cur_done, cur_wren;
  assign cur_busy = (sel == 0) ? busy_a : (sel == 1) ? busy_b : busy_c;
  assign cur_done = (sel == 0) ? done_a : (sel == 1) ? done_b : done_c;
  assign cur_wren = (sel == 0) ? wren_a : (sel == 1) ? wren_b : wren_c;

  task automatic model_ksa(input logic [23:0] kv);
    int j; logic [7:0] t, kb;
    for (int m = 0; m < 256; m++) exp8[m] = 8'(m);
    j = 0;
    for (int i = 0; i < 256; i++) begin
      kb = 8'(kv >> (8 * (2 - (i % 3))));
      j = (j + int'(exp8[i]) + int'(kb)) % 256;
      t = exp8[i]; exp8[i] = exp8[j]; exp8[j] = t;
    end
  endtask

  task automatic preload();
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Starts instance `which` and follows it until done, counting busy cycles and writes.
  task automatic run(input int which, input int budget, output int bcnt, output int wcnt,
                     output int fw, output logic b1, output logic d1, output bit to);
    sel = which;
    if (which == 0) start_a = 1'b1; else if (which == 1) start_b = 1'b1; else start_c = 1'b1;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    b1 = cur_busy; d1 = cur_done;
    bcnt = 0; wcnt = 0; fw = 0; to = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      if (cur_busy) bcnt++;
      if (cur_wren) begin wcnt++; if (fw == 0) fw = c; end
      if (cur_done) begin to = 1'b0; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL reset_done got %b want 0", done_a); else n_pass++;
    n_checks++; if (wren_a !== 1'b0) $display("FAIL reset_wren got %b want 0", wren_a); else n_pass++;
    n_checks++; if (addr_a !== 8'h00) $display("FAIL reset_addr got %h want 00", addr_a); else n_pass++;
    n_checks++; if (wdata_a !== 8'h00) $display("FAIL reset_wdata got %h want 00", wdata_a); else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_small_w2();
    int bc, wc, fw; logic b1, d1; bit to; int bad;
    logic [1:0] ec [4];
    ec[0] = 2'd0; ec[1] = 2'd2; ec[2] = 2'd3; ec[3] = 2'd1;
    preload();
    run(2, 500, bc, wc, fw, b1, d1, to);
    n_checks++; if (to) $display("FAIL w2_timeout got no done want done"); else n_pass++;
    n_checks++; if (bc !== 32 + 4 * FILL_ON) $display("FAIL w2_busy_len got %0d want %0d", bc, 32 + 4 * FILL_ON); else n_pass++;
    n_checks++; if (wc !== 8 + 4 * FILL_ON) $display("FAIL w2_writes got %0d want %0d", wc, 8 + 4 * FILL_ON); else n_pass++;
    bad = 0;
    for (int m = 0; m < 4; m++) if (mem_c[m] !== ec[m]) bad++;
    n_checks++; if (bad !== 0) $display("FAIL w2_memory got %0d %0d %0d %0d want 0 2 3 1", mem_c[0], mem_c[1], mem_c[2], mem_c[3]); else n_pass++;
  endtask

  task automatic test_full_lat1();
    int bc, wc, fw; logic b1, d1; bit to; int bad;
    key8 = 24'h4B6579;
    preload();
    run(0, 5000, bc, wc, fw, b1, d1, to);
    n_checks++; if (to) $display("FAIL l1_timeout got no done want done"); else n_pass++;
    n_checks++; if (bc !== 2048 + 256 * FILL_ON) $display("FAIL l1_busy_len got %0d want %0d", bc, 2048 + 256 * FILL_ON); else n_pass++;
    n_checks++; if (wc !== 512 + 256 * FILL_ON) $display("FAIL l1_writes got %0d want %0d", wc, 512 + 256 * FILL_ON); else n_pass++;
    n_checks++; if (fw !== ((FILL_ON != 0) ? 1 : 6)) $display("FAIL l1_first_write got %0d want %0d", fw, (FILL_ON != 0) ? 1 : 6); else n_pass++;
    n_checks++; if (b1 !== 1'b1) $display("FAIL l1_busy_cycle1 got %b want 1", b1); else n_pass++;
    bad = 0;
    for (int m = 0; m < 256; m++) if (mem_a[m] !== exp8[m]) bad++;
    n_checks++; if (bad !== 0) $display("FAIL l1_memory got %0d wrong words want 0", bad); else n_pass++;
    repeat (10) @(negedge clk);
    n_checks++; if (done_a !== 1'b1) $display("FAIL l1_done_hold got %b want 1", done_a); else n_pass++;
    n_checks++; if (busy_a !== 1'b0 || wren_a !== 1'b0) $display("FAIL l1_idle_in_done got busy=%b wren=%b want 0 0", busy_a, wren_a); else n_pass++;
  endtask

  task automatic test_full_lat3();
    int bc, wc, fw; logic b1, d1; bit to; int bad;
    key8 = 24'h4B6579;
    preload();
    run(1, 5000, bc, wc, fw, b1, d1, to);
    n_checks++; if (to) $display("FAIL l3_timeout got no done want done"); else n_pass++;
    n_checks++; if (bc !== 3072 + 256 * FILL_ON) $display("FAIL l3_busy_len got %0d want %0d", bc, 3072 + 256 * FILL_ON); else n_pass++;
    n_checks++; if (fw !== ((FILL_ON != 0) ? 1 : 10)) $display("FAIL l3_first_write got %0d want %0d", fw, (FILL_ON != 0) ? 1 : 10); else n_pass++;
    bad = 0;
    for (int m = 0; m < 256; m++) if (mem_b[m] !== exp8[m]) bad++;
    n_checks++; if (bad !== 0) $display("FAIL l3_memory got %0d wrong words want 0", bad); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int bc, wc, fw; logic b1, d1; bit to; int bad;
    key8 = 24'h4B6579;
    preload();
    run(0, 5000, bc, wc, fw, b1, d1, to);
    n_checks++; if (d1 !== 1'b0) $display("FAIL b2b_done_fall got %b want 0", d1); else n_pass++;
    n_checks++; if (b1 !== 1'b1) $display("FAIL b2b_busy_rise got %b want 1", b1); else n_pass++;
    n_checks++; if (bc !== 2048 + 256 * FILL_ON) $display("FAIL b2b_busy_len got %0d want %0d", bc, 2048 + 256 * FILL_ON); else n_pass++;
    bad = 0;
    for (int m = 0; m < 256; m++) if (mem_a[m] !== exp8[m]) bad++;
    n_checks++; if (bad !== 0) $display("FAIL b2b_memory got %0d wrong words want 0", bad); else n_pass++;
  endtask

  task automatic test_midrun_disturb();
    int bc, wc, fw; logic b1, d1; bit to; int bad;
    key8 = 24'h4B6579;
    preload();
    fork
      run(0, 5000, bc, wc, fw, b1, d1, to);
      begin
        repeat (300) @(negedge clk);
        key8 = 24'hFFFFFF; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0; key8 = 24'h123456;
      end
    join
    key8 = 24'h4B6579;
    n_checks++; if (bc !== 2048 + 256 * FILL_ON) $display("FAIL dist_busy_len got %0d want %0d", bc, 2048 + 256 * FILL_ON); else n_pass++;
    bad = 0;
    for (int m = 0; m < 256; m++) if (mem_a[m] !== exp8[m]) bad++;
    n_checks++; if (bad !== 0) $display("FAIL dist_memory got %0d wrong words want 0", bad); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    int bc, wc, fw; logic b1, d1; bit to; int bad, wr_after;
    key8 = 24'h4B6579;
    preload();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (499) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++; if (busy_a !== 1'b0) $display("FAIL rstmid_busy got %b want 0", busy_a); else n_pass++;
    n_checks++; if (done_a !== 1'b0) $display("FAIL rstmid_done got %b want 0", done_a); else n_pass++;
    n_checks++; if (wren_a !== 1'b0) $display("FAIL rstmid_wren got %b want 0", wren_a); else n_pass++;
    reset_n = 1'b1;
    wr_after = 0;
    repeat (5) begin @(negedge clk); if (wren_a) wr_after++; end
    n_checks++; if (wr_after !== 0) $display("FAIL rstmid_no_writes got %0d want 0", wr_after); else n_pass++;
    preload();
    run(0, 5000, bc, wc, fw, b1, d1, to);
    n_checks++; if (to) $display("FAIL rstmid_rerun_timeout got no done want done"); else n_pass++;
    bad = 0;
    for (int m = 0; m < 256; m++) if (mem_a[m] !== exp8[m]) bad++;
    n_checks++; if (bad !== 0) $display("FAIL rstmid_memory got %0d wrong words want 0", bad); else n_pass++;
  endtask

  initial begin
    load = 1'b0; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    key8 = 24'h4B6579; key2 = 2'b00; reset_n = 1'b0;
    model_ksa(24'h4B6579);
    @(negedge clk);
    test_reset();
    test_small_w2();
    test_full_lat1();
    test_full_lat3();
    test_back_to_back();
    test_midrun_disturb();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rc4_ksa_engine.md
RC4_KSA_ENGINE -- requirements
Module: rc4_ksa_engine

Interface
REQ-001 Parameter W, default 8: state word width; state depth N = 2^W; key byte width = W.
REQ-002 Parameter KEY_LEN, default 3, legal 1..32: number of key words.
REQ-003 Parameter RD_LAT, default 1, legal 1..3: memory read latency in cycles.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 start  in  1  run request; sampled in IDLE or DONE only.
REQ-007 key  in  KEY_LEN*W  key; word 0 in the most-significant W bits.
REQ-008 busy  out  1  high while a run is in progress.
REQ-009 done  out  1  high in DONE.
REQ-010 mem_addr  out  W  state memory address.
REQ-011 mem_wdata  out  W  state memory write data.
REQ-012 mem_wren  out  1  state memory write enable.
REQ-013 mem_rdata  in  W  read data, valid RD_LAT cycles after the cycle mem_addr was presented with mem_wren low.

Function
REQ-014 Memory outputs shall be Moore-decoded from state and registers; mem_wren is high only in FILL, WR_I and WR_J.
REQ-015 States: IDLE, FILL, RD_I, WAIT_I, CALC_J, RD_J, WAIT_J, WR_I, WR_J, NEXT, DONE.
REQ-016 start high in IDLE or DONE shall latch key, clear i, j and key index k, and go to FILL (macro on) or RD_I (macro off); start is ignored in all other states.
REQ-017 FILL: one cycle per address, mem_addr=i, mem_wdata=i, i increments; after i=N-1, i clears to 0 and the next state is RD_I.
REQ-018 RD_I: 1 cycle, mem_addr=i.
REQ-019 WAIT_I: RD_LAT cycles; si is captured from mem_rdata on the last edge.
REQ-020 CALC_J: 1 cycle; j <= (j + si + key word k) mod N.
REQ-021 RD_J: 1 cycle, mem_addr=j (new value).
REQ-022 WAIT_J: RD_LAT cycles; sj is captured on the last edge.
REQ-023 WR_I: mem_addr=i, mem_wdata=sj.
REQ-024 WR_J: mem_addr=j, mem_wdata=si.
REQ-025 i==j: both writes go to the same address with the same value; the word is unchanged.
REQ-026 NEXT: if i==N-1, go to DONE; else i <= i+1, k <= (k==KEY_LEN-1) ? 0 : k+1, and go to RD_I. No divider; KEY_LEN=1 keeps k=0.
REQ-027 Shuffle phase length: N*(6+2*RD_LAT) cycles; fill phase length: N cycles.
REQ-028 busy shall be high from the cycle after start is accepted through the NEXT cycle of the final iteration.
REQ-029 done shall rise in the cycle after that NEXT cycle, hold while in DONE, and fall the cycle after a new start is accepted.
REQ-030 Changes on key during a run shall have no effect; the latched copy is used.
REQ-031 All index arithmetic is W bits wide and wraps mod N.

Reset
REQ-032 reset_n low at a clock edge shall force IDLE, clear i, j, k, si, sj and the latched key, and drive busy=0, done=0, mem_wren=0, mem_addr=0, mem_wdata=0.
REQ-033 Reset mid-run shall abort immediately with no further writes; memory contents are left as partially shuffled.

Configuration
REQ-034 Macro RC4_KSA_INIT_FILL_EN defined: FILL state is present and every run first writes s[i]=i.
REQ-035 Macro RC4_KSA_INIT_FILL_EN undefined: FILL logic is absent; the run starts at RD_I on the preloaded memory contents, and busy length is N*(6+2*RD_LAT).

Verification
REQ-036 W=2, KEY_LEN=1, key=0, RD_LAT=1, macro on -> final memory [0,2,3,1]; busy high exactly 36 cycles.
REQ-037 W=8, KEY_LEN=3, key=0x4B6579, RD_LAT=1, macro on -> memory matches the software KSA model for all 256 words; busy high 2304 cycles; done held until the next start.
REQ-038 Same setup with RD_LAT=3 and the RAM model delayed accordingly -> identical final memory; busy high 256+256*12=3328 cycles.
REQ-039 reset_n low at cycle 500 of a run -> next edge: busy=0, done=0, mem_wren=0; a later start completes a correct full run.
REQ-040 Pulse start mid-run and change key mid-run -> no restart, result equals the run with the originally latched key.
REQ-041 Macro off, W=8, memory preloaded with identity, key=0x4B6579 -> result equals REQ-037; busy high 2048 cycles; no write occurs before the first WR_I.
